// File: rtl/clock_divider_mc.sv
// clock_divider_mc: multi-channel programmable divider with shadowed period/high config applied at wrap.
// Optional CLOCK_DIVIDER_MC_SYNC_EN adds sync_all to phase-align every programmed channel.
module clock_divider_mc #(
  parameter int NUM_CH = 4,
  parameter int CNT_W = 21,
  parameter int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [CNT_W-1:0]  cfg_high,
`ifdef CLOCK_DIVIDER_MC_SYNC_EN
  input  logic              sync_all,
`endif
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] cfg_pending
);
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CNT_W-1:0] r_p_sh, r_h_sh, r_p_act, r_h_act, r_cnt;
    logic r_out, r_tick, r_pend;
    logic w_wr, w_run, w_wrap, w_sync;
    assign w_wr   = cfg_we && (cfg_ch == CH_W'(g));
    assign w_run  = en[g] && (r_p_act != '0);
    assign w_wrap = r_cnt >= r_p_act - 1'b1;
`ifdef CLOCK_DIVIDER_MC_SYNC_EN
    assign w_sync = sync_all && (r_p_act != '0);
`else
    assign w_sync = 1'b0;
`endif
    always_ff @(posedge clk) begin
      if (rst) begin
        r_p_sh  <= '0;
        r_h_sh  <= '0;
        r_p_act <= '0;
        r_h_act <= '0;
        r_cnt   <= '0;
        r_out   <= 1'b0;
        r_tick  <= 1'b0;
        r_pend  <= 1'b0;
      end else begin
        if (w_sync || (w_run && w_wrap)) begin
          r_cnt  <= '0;
          r_tick <= 1'b1;
          if (r_pend) begin
            r_p_act <= r_p_sh;
            r_h_act <= r_h_sh;
            r_pend  <= 1'b0;
          end
        end else if (w_run) begin
          r_cnt  <= r_cnt + 1'b1;
          r_tick <= 1'b0;
        end else begin
          r_tick <= 1'b0;
          // a stopped channel takes new config immediately instead of waiting for a wrap
          if (r_pend) begin
            r_p_act <= r_p_sh;
            r_h_act <= r_h_sh;
            r_cnt   <= '0;
            r_pend  <= 1'b0;
          end
        end
        if (w_run) r_out <= r_cnt < r_h_act;
        if (w_wr) begin
          r_p_sh <= cfg_period;
          r_h_sh <= cfg_high;
          r_pend <= 1'b1;
        end
      end
    end
    assign clk_out[g]     = r_out;
    assign tick[g]        = r_tick;
    assign cfg_pending[g] = r_pend;
  end
endmodule

// File: doc/clock_divider_mc.md
Name: clock_divider_mc

Overview:
- Multi-channel programmable clock/tick generator; generalised successor of the single-channel toggle divider.
- Per channel: runtime-programmable period and high time (duty), per-channel enable, one-cycle period tick.
- Shadow-register config applied glitch-free at period boundaries.
- Feeds DAC sample strobes and SPI/serial bit clocks in the PL fabric, all in the single `clk` domain.

Parameters:
- NUM_CH, 4, number of independent divider channels (1..16).
- CNT_W, 21, width of the period, high-time and counter fields.
- CH_W, $clog2(NUM_CH) (min 1), width of the channel select.

Ports:
- clk  in  1  system clock; all logic posedge.
- rst  in  1  reset, synchronous, active-high.
- en  in  NUM_CH  per-channel run enable.
- cfg_we  in  1  config write strobe, one cycle.
- cfg_ch  in  CH_W  target channel of write.
- cfg_period  in  CNT_W  period P in clk cycles; 0 = channel stopped.
- cfg_high  in  CNT_W  high time H in clk cycles.
- clk_out  out  NUM_CH  divided clock per channel, registered.
- tick  out  NUM_CH  one-cycle pulse on counter wrap, registered.
- cfg_pending  out  NUM_CH  shadow written, not yet applied.

Behaviour:
- Per channel state:
  - shadow P_sh/H_sh and active P_act/H_act;
  - counter cnt (CNT_W);
  - pending flag.
- Reset values: all registers 0. So clk_out=0, tick=0, cfg_pending=0, P_act=0 (every channel stopped).
- Config write (cfg_we=1, cfg_ch<NUM_CH):
  - P_sh/H_sh <= inputs; pending <= 1.
  - cfg_ch >= NUM_CH: write ignored.
  - Repeated writes before apply: last write wins.
- Channel running (en=1 and P_act!=0), each clk:
  - wrap = (cnt >= P_act-1).
  - If wrap: cnt <= 0; tick <= 1; if pending was set before this edge: P_act/H_act <= shadow, pending <= 0.
  - Else: cnt <= cnt+1, tick <= 0.
  - clk_out <= (cnt < H_act), i.e. one-cycle latency from cnt to output.
  - Result: clk_out high for H_act cycles, low for P_act-H_act cycles.
- Duty boundaries:
  - H_act=0: clk_out constant 0.
  - H_act >= P_act: clk_out constant 1.
  - tick still pulses every P_act cycles in both cases.
- P_act=1: wrap every cycle, tick constant 1, clk_out = (H_act!=0).
- Channel idle (en=0 or P_act=0):
  - cnt, clk_out held; tick=0.
  - If pending: shadow applied next edge, cnt <= 0, pending <= 0. A stopped channel is reprogrammed without waiting for a wrap.
  - Applying P=0 stops the channel at its next wrap. clk_out keeps its last value; the next enabled run resumes from cnt=0.
- en rising with P_act!=0: counting resumes from held cnt (no reset of phase).
- Simultaneous write and wrap on the same channel:
  - wrap loads the previously pending shadow;
  - the new write lands in shadow and sets pending again, applied at the following wrap.
  - If nothing was pending before the edge, the new write is not applied at this wrap.
- Channels fully independent; no cross-channel ordering.
- rst mid-operation: all channels return to reset values on the next edge; pending writes lost.

Optional Feature:
- Macro: CLOCK_DIVIDER_MC_SYNC_EN.
- Defined:
  - Adds input port sync_all (1 bit).
  - When sync_all=1, every channel with P_act!=0 sets cnt <= 0 and tick <= 1 at that edge, regardless of en. Pending shadows are applied as on a wrap.
  - This phase-aligns all outputs. sync_all outranks normal wrap/increment; rst outranks sync_all.
- Not defined: no sync_all port; channels align only via reset or idle reprogramming.

Test Plan:
- Reset then idle 10 cycles -> clk_out=0, tick=0, cfg_pending=0 on all channels.
- ch0 write P=4,H=2, en[0]=1 -> cfg_pending[0] 1 for one cycle. Then clk_out[0] repeats 1,1,0,0; tick[0] every 4th cycle, coincident with cnt=3->0.
- ch0 running P=4,H=2; write P=6,H=3 at cnt=1 -> old pattern completes; new 3-high/3-low starts right after next tick; cfg_pending[0] drops at that wrap.
- ch1 P=5 with H=0, then H=5, then H=7 -> clk_out[1] constant 0, then constant 1, then constant 1; tick[1] every 5 cycles throughout.
- ch2 running, en[2]=0 for 7 cycles then 1 -> clk_out[2]/cnt frozen, tick[2]=0 while low; resumes same phase. Write during en=0 -> applied next cycle, cnt=0.
- With CLOCK_DIVIDER_MC_SYNC_EN: ch0 P=4, ch1 P=6 at different phases, pulse sync_all -> both tick next edge, both clk_out rise together; cfg_ch=NUM_CH write -> no change on any channel.
